// File: rtl/regfile_pkg.sv
// Shared widths, queue entry layout and slot encoding for the register-file
// write-back buffer.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SLOT_READ  = 1'b0,
        SLOT_WRITE = 1'b1
    } slot_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of pending register writes; exposes every slot's address, data
// and occupancy so the owner can search it for read hazards.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH*ADDR_W-1:0]      entry_addr,
    output logic [DEPTH*DATA_W-1:0]      entry_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr].addr <= push_addr;
                mem[wr_ptr].data <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar j = 0; j < DEPTH; j++) begin : g_slot
        logic [PTR_W-1:0] age;
        assign age                              = PTR_W'(j) - rd_ptr;
        assign entry_valid[j]                   = CNT_W'(age) < count;
        assign entry_addr[j*ADDR_W +: ADDR_W]   = mem[j].addr;
        assign entry_data[j*DATA_W +: DATA_W]   = mem[j].data;
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of the 32x32 register file: queues results, drains one
// per cycle, and arbitrates the file's mode line. Optional WB_BYPASS_EN forwards
// queued data to readers; without it a queued address stalls the read until drained.
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [ADDR_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic                        op_read_req,
    input  logic [ADDR_W-1:0]           op_read_addr,
    output logic [DATA_W-1:0]           op_read_value,
    output logic                        op_read_valid,
    output logic                        rf_mode,
    output logic [ADDR_W-1:0]           rf_write_addr,
    output logic [DATA_W-1:0]           rf_write_value,
    output logic [ADDR_W-1:0]           rf_read_addr,
    input  logic [DATA_W-1:0]           rf_read_value,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                    push, pop, full, hit;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [PTR_W-1:0]        rd_ptr, idx;
    logic [DEPTH-1:0]        entry_valid;
    logic [DEPTH*ADDR_W-1:0] entry_addr;
    logic [DEPTH*DATA_W-1:0] entry_data;
    logic [CNT_W-1:0]        count_next;
    logic [0:0]              state;
    slot_e                   slot;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .push_addr  (wb_addr),
        .push_data  (wb_data),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (full),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .entry_valid(entry_valid),
        .entry_addr (entry_addr),
        .entry_data (entry_data)
    );

    assign wb_ready   = !full;
    assign push       = wb_valid && !full;
    assign pop        = (slot == SLOT_WRITE);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= (count_next != '0) ? ST_DRAIN : ST_IDLE;
    end

`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] fwd;
`endif

    // Walk oldest to youngest so the last match is the youngest write.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef WB_BYPASS_EN
        fwd = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (entry_valid[idx] && entry_addr[int'(idx)*ADDR_W +: ADDR_W] == op_read_addr) begin
                hit = 1'b1;
`ifdef WB_BYPASS_EN
                fwd = entry_data[int'(idx)*DATA_W +: DATA_W];
`endif
            end
        end
    end

    assign slot = ((state == ST_DRAIN) && (!op_read_req || hit || full)) ? SLOT_WRITE : SLOT_READ;

    assign rf_mode        = (slot == SLOT_WRITE);
    assign rf_write_addr  = rf_mode ? head_addr : '0;
    assign rf_write_value = rf_mode ? head_data : '0;
    assign rf_read_addr   = op_read_addr;

`ifdef WB_BYPASS_EN
    assign op_read_valid = op_read_req && (hit || slot == SLOT_READ);
    assign op_read_value = !op_read_valid ? '0 : (hit ? fwd : rf_read_value);
`else
    logic unused_data;
    assign unused_data   = ^entry_data;
    assign op_read_valid = op_read_req && (slot == SLOT_READ);
    assign op_read_value = op_read_valid ? rf_read_value : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Randomized and directed bench for regfile_wb_buffer with a register-file model,
// an architectural-state reference and a write-order scoreboard.
module tb_regfile_wb_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        op_read_req, op_read_valid;
    logic [4:0]  op_read_addr;
    logic [31:0] op_read_value;
    logic        rf_mode;
    logic [4:0]  rf_write_addr, rf_read_addr;
    logic [31:0] rf_write_value, rf_read_value;
    logic [2:0]  count;

    regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_read_req(op_read_req), .op_read_addr(op_read_addr),
        .op_read_value(op_read_value), .op_read_valid(op_read_valid),
        .rf_mode(rf_mode), .rf_write_addr(rf_write_addr), .rf_write_value(rf_write_value),
        .rf_read_addr(rf_read_addr), .rf_read_value(rf_read_value), .count(count)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write on the edge while mode=1.
    logic [31:0] rf_file [32] = '{default: '0};
    assign rf_read_value = rf_file[rf_read_addr];
    always @(posedge clk) if (rst_n && rf_mode) rf_file[rf_write_addr] <= rf_write_value;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: queued writes in acceptance order, plus the value every register
    // should read as once all accepted writes are applied.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t        sbq[$];
    logic [31:0] arch [32] = '{default: '0};

    always @(negedge clk) begin
        int   n;
        logic hit, exp_mode, exp_valid;
        ent_t e;
        if (!rst_n) begin
            sbq.delete();
            arch = rf_file;
        end else begin
            n   = sbq.size();
            hit = 1'b0;
            foreach (sbq[i]) if (sbq[i].a == op_read_addr) hit = 1'b1;
            exp_mode = (n > 0) && (!op_read_req || hit || n == DEPTH);
`ifdef WB_BYPASS_EN
            exp_valid = op_read_req && (hit || !exp_mode);
`else
            exp_valid = op_read_req && !exp_mode;
`endif
            chk("count", count, n);
            chk("wb_ready", wb_ready, n < DEPTH);
            chk("rf_mode", rf_mode, exp_mode);
            chk("op_read_valid", op_read_valid, exp_valid);
            chk("rf_read_addr", rf_read_addr, op_read_addr);
            if (exp_valid && op_read_valid)
                chk("op_read_value", op_read_value, arch[op_read_addr]);
            if (exp_mode && rf_mode) begin
                e = sbq.pop_front();
                chk("rf_write_addr", rf_write_addr, e.a);
                chk("rf_write_value", rf_write_value, e.d);
            end
            if (wb_valid && n < DEPTH) begin
                e.a = wb_addr;
                e.d = wb_data;
                sbq.push_back(e);
                arch[wb_addr] = wb_data;
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic rq, input logic [4:0] ra);
        wb_valid     = v;
        wb_addr      = a;
        wb_data      = d;
        op_read_req  = rq;
        op_read_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            if (count == 0) break;
            tick();
        end
        chk(nm, count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        chk("rst count", count, 0);
        chk("rst wb_ready", wb_ready, 1);
        chk("rst rf_mode", rf_mode, 0);
        chk("rst rf_write_addr", rf_write_addr, 0);
        chk("rst rf_write_value", rf_write_value, 0);
        chk("rst op_read_valid", op_read_valid, 0);
        chk("rst op_read_value", op_read_value, 0);
        #10 rst_n = 1'b1;
        tick();

        // Single push drains the following cycle.
        drive(1, 3, 32'hDEADBEEF, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        chk("t1 rf_mode", rf_mode, 1);
        chk("t1 rf_write_addr", rf_write_addr, 3);
        chk("t1 rf_write_value", rf_write_value, 32'hDEADBEEF);
        tick();
        #2 chk("t1 count", count, 0);
        tick();

        // Fill while reading an unrelated register; full forces a drain.
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(10 + i), $urandom, 1, 9);
            tick();
        end
        drive(0, 0, 0, 1, 9);
        #2;
        chk("t2 count full", count, 4);
        chk("t2 wb_ready full", wb_ready, 0);
        chk("t2 stall valid", op_read_valid, 0);
        chk("t2 drain on full", rf_mode, 1);
        tick();
        #2 chk("t2 read resumes", op_read_valid, 1);
        tick();
        drain("t2 drain timeout");

        // Two writes to the same register, then read it.
        drive(1, 5, 32'h11, 1, 9);
        tick();
        drive(1, 5, 32'h22, 1, 9);
        tick();
        drive(0, 0, 0, 1, 5);
        waited = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (op_read_valid) break;
            waited++;
            tick();
        end
`ifdef WB_BYPASS_EN
        chk("t3 bypass latency", waited, 0);
`else
        chk("t3 hazard stall cycles", waited, 2);
`endif
        chk("t3 youngest value", op_read_value, 32'h22);
        tick();
        drain("t3 drain timeout");

        // Simultaneous push and pop at count=2.
        drive(1, 12, $urandom, 1, 9);
        tick();
        drive(1, 13, $urandom, 1, 9);
        tick();
        drive(1, 14, $urandom, 0, 0);
        #2;
        chk("t4 count before", count, 2);
        chk("t4 pop active", rf_mode, 1);
        tick();
        #2 chk("t4 count after push+pop", count, 2);
        drive(1, 15, $urandom, 0, 0);
        tick();
        drive(1, 16, $urandom, 0, 0);
        tick();
        drain("t4 drain timeout");

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 32'hA0 + i, 1, 9);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1 chk("t5 draining", rf_mode, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 async count", count, 0);
        chk("t5 async rf_mode", rf_mode, 0);
        chk("t5 async wb_ready", wb_ready, 1);
        tick();
        chk("t5 no write landed", rf_file[20], 0);
        #1 rst_n = 1'b1;
        tick();

        // Empty buffer serves reads straight from the file.
        drive(0, 0, 0, 1, 7);
        #2;
        chk("t6 rf_mode", rf_mode, 0);
        chk("t6 valid", op_read_valid, 1);
        chk("t6 value", op_read_value, rf_file[7]);
        tick();

        // Random traffic on a small address range to provoke hits.
        for (int c = 0; c < 1500; c++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 9)));
            tick();
        end
        drain("rand drain timeout");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
